// File: rtl/tck_sched_pkg.sv
// Shared types and helpers for the TCK tick-burst scheduler.
// Holds the burst FSM states, the default widths and the tap-select range check.
package tck_sched_pkg;

    localparam int unsigned TAP_W_DEF = 14;
    localparam int unsigned SEL_W_DEF = 4;
    localparam int unsigned LEN_W_DEF = 16;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRun,
        StDone
    } state_e;

    // A tap index is usable only if it addresses an existing prescaler bit.
    function automatic logic sel_valid(input int unsigned sel, input int unsigned tap_w);
        return sel < tap_w;
    endfunction

endpackage

// File: rtl/tap_edge_det.sv
// Rising-edge detector on one selectable bit of the prescaler count vector.
// While rearm is high the history is loaded but no edge is reported.
module tap_edge_det
    import tck_sched_pkg::*;
#(
    parameter int unsigned TAP_W = TAP_W_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [TAP_W-1:0] tap_in,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic             rearm,
    output logic             rise
);

    logic tap_bit;
    logic tap_prev;

    always_comb begin
        tap_bit = 1'b0;
        for (int i = 0; i < TAP_W; i++) begin
            if (sel == SEL_W'(i)) begin
                tap_bit = tap_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_prev <= 1'b0;
        end else if (en) begin
            tap_prev <= tap_bit;
        end
    end

    assign rise = en & ~rearm & tap_bit & ~tap_prev;

endmodule

// File: rtl/tck_sched.sv
// Emits a software-sized burst of single-cycle TCK enable ticks, one per
// rising edge of a selected prescaler tap, then pulses done.
module tck_sched
    import tck_sched_pkg::*;
#(
    parameter int unsigned TAP_W = TAP_W_DEF,
    parameter int unsigned SEL_W = SEL_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [TAP_W-1:0] tap_in,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] remaining
);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [LEN_W-1:0] len_q;

    logic             cfg_hs;
    logic             cfg_ok;
    logic [LEN_W-1:0] eff_len;
    logic             det_en;
    logic             det_rearm;
    logic             rise;

    assign cfg_hs    = cfg_valid & cfg_ready;
    assign cfg_ok    = sel_valid(32'(cfg_sel), TAP_W);
    // A start in the same cycle as an accepted config uses the new length.
    assign eff_len   = (cfg_hs && cfg_ok) ? cfg_len : len_q;
    assign det_en    = (state_q == StArm) || (state_q == StRun);
    assign det_rearm = (state_q == StArm);

    tap_edge_det #(
        .TAP_W (TAP_W),
        .SEL_W (SEL_W)
    ) u_tap_edge_det (
        .clk     (clk),
        .reset_n (reset_n),
        .tap_in  (tap_in),
        .sel     (sel_q),
        .en      (det_en),
        .rearm   (det_rearm),
        .rise    (rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            len_q     <= '0;
            remaining <= '0;
            tick      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            tick    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            cfg_err <= 1'b0;

            if (cfg_hs) begin
                if (cfg_ok) begin
                    sel_q <= cfg_sel;
                    len_q <= cfg_len;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (eff_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= eff_len;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                            state_q   <= StArm;
                        end
                    end
                end
                StArm: begin
                    if (stop) begin
                        aborted   <= 1'b1;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    // stop wins over a coincident edge: no tick, no decrement.
                    if (stop) begin
                        aborted   <= 1'b1;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        state_q   <= StIdle;
                    end else if (rise && (remaining != '0)) begin
                        tick      <= 1'b1;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tck_sched.sv
// Directed self-checking bench for tck_sched with a free-running prescaler model.
module tb_tck_sched;

    localparam int unsigned TAP_W = 14;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [TAP_W-1:0] tap_in;
    logic [SEL_W-1:0] cfg_sel;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic             start;
    logic             stop;
    logic             tick;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [LEN_W-1:0] remaining;

    logic [TAP_W-1:0] tap_cnt = '0;

    int n_checks = 0;
    int n_fail   = 0;

    int w_ticks, w_first, w_gmin, w_gmax, w_done_after, w_last;
    bit w_done, w_abort, w_busy_ok;
    logic [LEN_W-1:0] rem_log [16];

    tck_sched #(
        .TAP_W (TAP_W),
        .SEL_W (SEL_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tap_in    (tap_in),
        .cfg_sel   (cfg_sel),
        .cfg_len   (cfg_len),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Prescaler model: free-running up-counter on the same clock.
    always @(posedge clk) tap_cnt <= tap_cnt + 1'b1;
    assign tap_in = tap_cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Observe one burst at negedges until done/aborted or the budget expires.
    task automatic watch(input int budget);
        w_ticks = 0; w_first = -1; w_gmin = 100000; w_gmax = 0;
        w_done = 0; w_abort = 0; w_busy_ok = 1; w_done_after = -1; w_last = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                w_done = 1;
                w_done_after = c - w_last;
                break;
            end
            if (aborted) begin
                w_abort = 1;
                break;
            end
            if (!busy) w_busy_ok = 0;
            if (tick) begin
                if (w_ticks < 16) rem_log[w_ticks] = remaining;
                if (w_last >= 0) begin
                    if (c - w_last < w_gmin) w_gmin = c - w_last;
                    if (c - w_last > w_gmax) w_gmax = c - w_last;
                end
                if (w_first < 0) w_first = c;
                w_last = c;
                w_ticks++;
            end
        end
    endtask

    task automatic do_cfg(input int sel, input int len);
        cfg_sel   = SEL_W'(sel);
        cfg_len   = LEN_W'(len);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0; cfg_sel = '0; cfg_len = '0; cfg_valid = 1'b0;
        start = 1'b0; stop = 1'b0;
        #23;
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_flags", {29'd0, done, aborted, cfg_err}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: sel=0 len=3
        do_cfg(0, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t1_arm_busy", 32'(busy), 1);
        chk("t1_arm_rem", 32'(remaining), 3);
        chk("t1_arm_ready", 32'(cfg_ready), 0);
        watch(100);
        chk("t1_ticks", 32'(w_ticks), 3);
        chk("t1_gap_min", 32'(w_gmin), 2);
        chk("t1_gap_max", 32'(w_gmax), 2);
        chk("t1_done", 32'(w_done), 1);
        chk("t1_done_after", 32'(w_done_after), 1);
        chk("t1_busy_thru", 32'(w_busy_ok), 1);
        chk("t1_rem0", 32'(rem_log[0]), 2);
        chk("t1_rem1", 32'(rem_log[1]), 1);
        chk("t1_rem2", 32'(rem_log[2]), 0);
        chk("t1_busy_at_done", 32'(busy), 0);

        // 2: sel=5 len=2, start while bit 5 is already high
        do_cfg(5, 2);
        cnt = 0;
        while (tap_cnt[5:0] != 6'd32 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("t2_align", 32'(tap_cnt[5:0]), 32);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_arm_rem", 32'(remaining), 2);
        watch(300);
        chk("t2_ticks", 32'(w_ticks), 2);
        chk("t2_first", 32'(w_first), 63);
        chk("t2_gap", 32'(w_gmin), 64);
        chk("t2_done", 32'(w_done), 1);

        // 3: out-of-range select is rejected, previous sel/len kept
        cfg_sel = 4'd14; cfg_len = 16'd5; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("t3_err", 32'(cfg_err), 1);
        @(negedge clk);
        chk("t3_err_once", 32'(cfg_err), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3_arm_rem", 32'(remaining), 2);
        watch(300);
        chk("t3_ticks", 32'(w_ticks), 2);
        chk("t3_gap", 32'(w_gmin), 64);
        chk("t3_done", 32'(w_done), 1);

        // 4: len=0 with cfg and start in the same cycle
        cfg_sel = 4'd0; cfg_len = 16'd0; cfg_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
        chk("t4_done", 32'(done), 1);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_tick", 32'(tick), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tick || busy || done) cnt++;
        end
        chk("t4_quiet", 32'(cnt), 0);

        // 5: sel=1 len=10, stop coincident with the 5th edge
        do_cfg(1, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick) cnt++;
            if (cnt == 4) break;
        end
        chk("t5_four_ticks", 32'(cnt), 4);
        chk("t5_rem_at4", 32'(remaining), 6);
        repeat (3) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t5_aborted", 32'(aborted), 1);
        chk("t5_no_tick", 32'(tick), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_rem", 32'(remaining), 6);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tick || done || aborted) cnt++;
        end
        chk("t5_quiet", 32'(cnt), 0);

        // 6: reset mid-run, then a fresh burst
        do_cfg(0, 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tick) cnt++;
            if (cnt == 2) break;
        end
        chk("t6_pre_tick", 32'(tick), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_tick", 32'(tick), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_rem", 32'(remaining), 0);
        chk("t6_rst_flags", {30'd0, done, aborted}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_ready", 32'(cfg_ready), 1);
        do_cfg(0, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_arm_rem", 32'(remaining), 2);
        watch(100);
        chk("t6_ticks", 32'(w_ticks), 2);
        chk("t6_gap", 32'(w_gmin), 2);
        chk("t6_done_after", 32'(w_done_after), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tck_sched.md
Name: tck_sched

Overview:
- Schedules bursts of clock-enable ticks derived from the free-running prescaler count vector.
- Software selects one prescaler tap and a tick count; the block emits exactly that many single-cycle tick pulses, one per rising edge of the selected tap, then reports completion.
- Sits between the prescaler and the scan/test sequencers that need a slow, countable TCK enable.
- Reconfiguration is only allowed while idle, so the tick rate never changes mid-burst.

Parameters:
- TAP_W, 14, width of the prescaler count vector.
- SEL_W, 4, width of the tap select field.
- LEN_W, 16, width of the burst length and remaining-count registers.

Ports:
- clk  in  1  system clock; same clock that drives the prescaler.
- reset_n  in  1  asynchronous, active-low reset.
- tap_in  in  TAP_W  prescaler count vector, synchronous to clk.
- cfg_sel  in  SEL_W  requested tap index; valid range 0..TAP_W-1.
- cfg_len  in  LEN_W  requested number of ticks per burst.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  high while a configuration can be accepted.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- start  in  1  one-cycle burst request.
- stop  in  1  abort request.
- tick  out  1  one-cycle clock-enable pulse.
- busy  out  1  high from burst start until done or aborted.
- done  out  1  one-cycle pulse when a burst completes.
- aborted  out  1  one-cycle pulse when a burst is stopped.
- remaining  out  LEN_W  ticks still to be issued in the current burst.

Behaviour:
- Reset (asynchronous assert): state=IDLE, sel_r=0, len_r=0, remaining=0, tick=0, busy=0, done=0, aborted=0, cfg_err=0, cfg_ready=1, tap_prev=0.
- All outputs are registered.
- Configuration:
  - cfg_ready=1 only in IDLE.
  - A handshake occurs when cfg_valid & cfg_ready.
  - If cfg_sel < TAP_W: sel_r<=cfg_sel and len_r<=cfg_len.
  - Otherwise sel_r and len_r are unchanged and cfg_err pulses in the next cycle.
  - cfg_valid outside IDLE is ignored: no error, no effect.
- States:
  - IDLE:
    - start with len_r=0: done pulses next cycle; no ticks; state stays IDLE.
    - start with len_r>0: remaining<=len_r, busy<=1, go to ARM.
    - If start and cfg_valid arrive in the same cycle, configuration is applied first and start uses the new values.
  - ARM (exactly 1 cycle):
    - tap_prev<=tap_in[sel_r].
    - Go to RUN.
    - Purpose: no spurious edge when the selected tap is already high at start.
  - RUN:
    - Each cycle, tap_prev<=tap_in[sel_r].
    - Rising edge = tap_in[sel_r] & ~tap_prev.
    - On a rising edge: tick<=1 in the next cycle and remaining<=remaining-1.
    - When that decrement reaches 0: go to DONE.
  - DONE (1 cycle): done=1, busy<=0, go to IDLE.
- Latency: tap rises at clk edge n, tick is high in cycle n+1.
- Tick rate: one tick per 2^(sel+1) clk cycles.
  - sel=0: a tick every 2nd cycle.
  - Ticks are never adjacent for any sel.
- stop:
  - In ARM or RUN: next cycle go to IDLE, aborted=1, busy=0; remaining holds its value.
  - If stop coincides with a rising edge, that tick is suppressed and remaining is not decremented.
  - stop in IDLE or DONE is ignored; done still pulses.
- start while busy is ignored.
- remaining never wraps; a decrement from 0 cannot occur.
- Reset asserted mid-burst: everything returns to reset values immediately; no done or aborted pulse.
- tap_in is not required to be a counter: the block reacts only to 0->1 transitions of the selected bit.

Decomposition:
- Shared package tck_sched_pkg:
  - State enum: IDLE, ARM, RUN, DONE.
  - Constants TAP_W_DEF=14, SEL_W_DEF=4, LEN_W_DEF=16.
  - Function sel_valid(sel, tap_w).
- One sub-module, tap_edge_det:
  - Contains the selected-bit mux, the tap_prev register, a re-arm input (driven by ARM) and the rise output.
  - Everything else stays in the top.

Test Plan:
1. Reset, cfg sel=0 len=3, start; tap_in driven by a counter → 3 ticks spaced 2 cycles apart, done 1 cycle after the last tick, busy high throughout, remaining 3→2→1→0.
2. cfg sel=5 len=2, start while tap_in[5] is already high → no tick until the next 0→1 of bit 5; ticks 64 cycles apart; done pulses.
3. cfg sel=14 → cfg_err pulses once, sel_r unchanged; a following start uses the previous sel and len.
4. cfg len=0, start → done pulses next cycle, no tick, busy stays 0.
5. sel=1 len=10, stop asserted after the 4th tick, coinciding with an edge → no 5th tick, aborted pulses, remaining=6, no done.
6. Assert reset_n low mid-RUN for 1 cycle → tick, busy and remaining are 0 immediately; after release, cfg_ready=1 and a new start works normally.
